morphle_cfg_loader: RTL

//  Wishbone-slave configuration loader for the Morphle Logic array, placed inside the user project

---
 rtl/morphle_cfg_loader.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/morphle_cfg_loader.sv
// Morphle Logic configuration loader.
// Wishbone slave that shifts a software-written word bit-serially into one of
// CHAINS config chains under a programmable divided clock, captures the bits
// returning from the same chain, and flags completion with a level interrupt.
module morphle_cfg_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          CHAINS    = 4,
   parameter int          DIV_W     = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [CHAINS-1:0] cfg_clk_o,
   output logic [CHAINS-1:0] cfg_data_o,
   input  logic [CHAINS-1:0] cfg_data_i,
   output logic              cfg_reset_o,
   output logic              irq_o
);

   // 9 bits so that CHAINS = 256 still compares correctly against an 8-bit select
   localparam logic [8:0] CHAINS_L = 9'(CHAINS);

   localparam logic [2:0] OFS_CTRL   = 3'd0;
   localparam logic [2:0] OFS_STATUS = 3'd1;
   localparam logic [2:0] OFS_TXDATA = 3'd2;
   localparam logic [2:0] OFS_RXDATA = 3'd3;
   localparam logic [2:0] OFS_DIV    = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } state_t;

   state_t state_q, state_d;

   // bus capture stage (hit cycle -> ack cycle)
   logic              ack_p1;
   logic              we_p1;
   logic [2:0]        adr_p1;
   logic [31:0]       wdat_p1;
   logic [31:0]       rdat_p1;

   logic              hit;
   logic [31:0]       rd_mux;

   // architectural registers
   logic              cfg_rst_q;
   logic              irq_en_q;
   logic [4:0]        nb_q;
   logic [7:0]        sel_q;
   logic              done_q;
   logic              ovr_q;
   logic [31:0]       tx_q;
   logic [31:0]       rx_q;
   logic [DIV_W-1:0]  div_q;

   // shift engine state, latched when a shift starts
   logic [7:0]        cur_sel_q;
   logic [DIV_W-1:0]  div_lat_q;
   logic [DIV_W-1:0]  cnt_q;
   logic [4:0]        bits_q;

   logic              wr_go, wr_ctrl, wr_stat, wr_tx, wr_div;
   logic              busy_now, busy_bit, sel_ok, start_req, start_ok, ovr_set;
   logic              capture, shift_tx, set_done;
   logic              din_sel;

   // byte selects and the aliased offset bits carry no meaning here
   logic              unused_bus;
   assign unused_bus = ^{wbs_sel_i, wbs_adr_i[7:5], wbs_adr_i[1:0]};

   assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

   // Writes are applied at the end of the ack cycle, using the values captured at the hit.
   assign wr_go   = ack_p1 & we_p1;
   assign wr_ctrl = wr_go & (adr_p1 == OFS_CTRL);
   assign wr_stat = wr_go & (adr_p1 == OFS_STATUS);
   assign wr_tx   = wr_go & (adr_p1 == OFS_TXDATA);
   assign wr_div  = wr_go & (adr_p1 == OFS_DIV);

   // DONE counts as busy for bus-side locking so a start cannot collide with the wrap to IDLE
   assign busy_now  = (state_q != ST_IDLE);
   assign busy_bit  = (state_q == ST_LOW) | (state_q == ST_HIGH);
   assign sel_ok    = ({1'b0, wdat_p1[23:16]} < CHAINS_L);
   assign start_req = wr_ctrl & wdat_p1[0];
   assign start_ok  = start_req & sel_ok & ~busy_now;
   assign ovr_set   = (start_req & (busy_now | ~sel_ok)) | ((wr_tx | wr_div) & busy_now);

   assign cfg_reset_o = cfg_rst_q;
   assign irq_o       = done_q & irq_en_q;
   assign wbs_ack_o   = ack_p1;
   assign wbs_dat_o   = rdat_p1;

   // Read mux, sampled at the hit cycle.
   always_comb begin
      rd_mux = 32'h0;
      case (wbs_adr_i[4:2])
         OFS_CTRL:   rd_mux = {8'h0, sel_q, 3'b000, nb_q, 4'h0, irq_en_q, cfg_rst_q, 2'b00};
         OFS_STATUS: rd_mux = {29'h0, ovr_q, done_q, busy_bit};
         OFS_TXDATA: rd_mux = tx_q;
         OFS_RXDATA: rd_mux = rx_q;
         OFS_DIV:    rd_mux = 32'(div_q);
         default:    rd_mux = 32'h0;
      endcase
   end

   // Registered single-cycle ack plus capture of the access for the ack cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ack_p1  <= 1'b0;
         we_p1   <= 1'b0;
         adr_p1  <= 3'd0;
         wdat_p1 <= 32'h0;
         rdat_p1 <= 32'h0;
      end else begin
         ack_p1 <= hit & ~ack_p1;
         if (hit & ~ack_p1) begin
            we_p1   <= wbs_we_i;
            adr_p1  <= wbs_adr_i[4:2];
            wdat_p1 <= wbs_dat_i;
            rdat_p1 <= wbs_we_i ? 32'h0 : rd_mux;
         end else begin
            rdat_p1 <= 32'h0;
         end
      end
   end

   // Shift sequencer: state register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Shift sequencer: next state and per-cycle strobes.
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      shift_tx = 1'b0;
      set_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_LOW;
         end
         ST_LOW: begin
            if (cnt_q == '0) begin
               state_d = ST_HIGH;
               capture = 1'b1;
            end
         end
         ST_HIGH: begin
            if (cnt_q == '0) begin
               shift_tx = 1'b1;
               if (bits_q == 5'd0) begin
                  state_d  = ST_DONE;
                  set_done = 1'b1;
               end else begin
                  state_d = ST_LOW;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Phase timer and bit counter; the timer reloads on every phase change.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         cnt_q     <= '0;
         div_lat_q <= '0;
         bits_q    <= 5'd0;
         cur_sel_q <= 8'h0;
      end else begin
         if (start_ok) begin
            cnt_q     <= div_q;
            div_lat_q <= div_q;
            bits_q    <= wdat_p1[12:8];
            cur_sel_q <= wdat_p1[23:16];
         end else begin
            if (state_d != state_q) begin
               cnt_q <= div_lat_q;
            end else if (cnt_q != '0) begin
               cnt_q <= cnt_q - 1'b1;
            end
            if (shift_tx && bits_q != 5'd0) begin
               bits_q <= bits_q - 5'd1;
            end
         end
      end
   end

   // Control and status registers; a completing shift wins over a same-cycle W1C.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         cfg_rst_q <= 1'b0;
         irq_en_q  <= 1'b0;
         nb_q      <= 5'd0;
         sel_q     <= 8'h0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            cfg_rst_q <= wdat_p1[2];
            irq_en_q  <= wdat_p1[3];
            if (!busy_now) begin
               nb_q  <= wdat_p1[12:8];
               sel_q <= wdat_p1[23:16];
            end
         end
         if (set_done) begin
            done_q <= 1'b1;
         end else if (wr_stat && wdat_p1[1]) begin
            done_q <= 1'b0;
         end
         if (ovr_set) begin
            ovr_q <= 1'b1;
         end else if (wr_stat && wdat_p1[2]) begin
            ovr_q <= 1'b0;
         end
      end
   end

   // Data registers: TXDATA doubles as the outgoing shift register, RXDATA fills from the LSB.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         tx_q  <= 32'h0;
         rx_q  <= 32'h0;
         div_q <= '0;
      end else begin
         if (wr_tx && !busy_now) begin
            tx_q <= wdat_p1;
         end else if (shift_tx) begin
            tx_q <= {1'b0, tx_q[31:1]};
         end
         if (start_ok) begin
            rx_q <= 32'h0;
         end else if (capture) begin
            rx_q <= {rx_q[30:0], din_sel};
         end
         if (wr_div && !busy_now) begin
            div_q <= wdat_p1[DIV_W-1:0];
         end
      end
   end

   // Chain fan-out: only the latched chain sees clock and data; all others stay low.
   always_comb begin
      cfg_clk_o  = '0;
      cfg_data_o = '0;
      din_sel    = 1'b0;
      for (int i = 0; i < CHAINS; i++) begin
         if (cur_sel_q == 8'(i)) begin
            cfg_clk_o[i]  = (state_q == ST_HIGH);
            cfg_data_o[i] = busy_bit & tx_q[0];
            din_sel       = cfg_data_i[i];
         end
      end
   end

endmodule
